// File: rtl/mac_share_arbiter_if.sv
// Bundle between the requester engines, the MAC instance and the result sink
// for mac_share_arbiter. The slave modport is the arbiter's view and the master
// modport is the surrounding environment's view.
interface mac_share_arbiter_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned OUTPUT_WIDTH = 40
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_a;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]             req_ready;

    logic [INPUT_WIDTH-1:0]         mac_a;
    logic [INPUT_WIDTH-1:0]         mac_b;
    logic                           mac_valid;
    logic                           mac_clr;
    logic [OUTPUT_WIDTH-1:0]        mac_out_val;
    logic                           mac_out_valid;

    logic                           res_valid;
    logic [ID_WIDTH-1:0]            res_id;
    logic [OUTPUT_WIDTH-1:0]        res_val;
    logic                           res_trunc;
    logic                           busy;

    modport slave (
        input  req_valid, req_last, req_a, req_b, mac_out_val, mac_out_valid,
        output req_ready, mac_a, mac_b, mac_valid, mac_clr,
               res_valid, res_id, res_val, res_trunc, busy
    );

    modport master (
        output req_valid, req_last, req_a, req_b, mac_out_val, mac_out_valid,
        input  req_ready, mac_a, mac_b, mac_valid, mac_clr,
               res_valid, res_id, res_val, res_trunc, busy
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: grants whole operand vectors to one shared pipelined MAC in
// round-robin order, tags every issued beat and returns each vector's final
// accumulation to its owner.
// Optional feature: define MAC_ARB_BURST_LIMIT_EN to cap every vector at
// MAX_BURST beats; the remainder of a capped vector is granted again later.
module mac_share_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned OUTPUT_WIDTH = 40,
    parameter int unsigned MAC_LATENCY  = 3,
    parameter int unsigned MAX_BURST    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_share_arbiter_if.slave    bus
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);
    localparam int unsigned LAST_TAG = MAC_LATENCY - 1;
`ifdef MAC_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
`endif

    // Reject configurations outside the supported range at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAC_LATENCY < 1 || MAX_BURST < 1) begin : g_bad_param
        $error("mac_share_arbiter: illegal parameter set");
    end

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [ID_WIDTH-1:0] id;
        logic                trunc;
    } tag_t;

    state_t                  state, state_n;
    logic [ID_WIDTH-1:0]     owner, owner_n;
    logic [ID_WIDTH-1:0]     rr_ptr, rr_n;
    logic                    first_q, first_n;
    logic [NUM_REQ-1:0]      ready_q, ready_n;
    logic [INPUT_WIDTH-1:0]  mac_a_q, mac_a_n;
    logic [INPUT_WIDTH-1:0]  mac_b_q, mac_b_n;
    logic                    mac_clr_q, mac_clr_n;
    tag_t                    issue_q, issue_n;
    tag_t                    pipe_q [MAC_LATENCY];
    tag_t                    pipe_n [MAC_LATENCY];
    logic                    res_valid_q, res_valid_n;
    logic [ID_WIDTH-1:0]     res_id_q, res_id_n;
    logic [OUTPUT_WIDTH-1:0] res_val_q, res_val_n;
    logic                    res_trunc_q, res_trunc_n;
    logic                    busy_q, busy_n;
`ifdef MAC_ARB_BURST_LIMIT_EN
    logic [CNT_WIDTH-1:0]    beat_cnt, cnt_n;
`endif

    logic [ID_WIDTH:0]       scan_sum;
    logic [ID_WIDTH-1:0]     pick;
    logic                    found;
    logic                    fire;
    logic                    tag_last;
    logic                    tag_trunc;

    // Next-state: grant scan, burst acceptance, tag pipe advance and result capture.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_n        = rr_ptr;
        first_n     = first_q;
        mac_a_n     = mac_a_q;
        mac_b_n     = mac_b_q;
        scan_sum    = '0;
        pick        = '0;
        found       = 1'b0;
        fire        = 1'b0;
        tag_last    = 1'b0;
        tag_trunc   = 1'b0;
`ifdef MAC_ARB_BURST_LIMIT_EN
        cnt_n       = beat_cnt;
`endif

        // Descending scan so the requester closest to rr_ptr (upward, wrapping) wins.
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            scan_sum = (ID_WIDTH+1)'(rr_ptr) + (ID_WIDTH+1)'(k);
            if (scan_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (bus.req_valid[ID_WIDTH'(scan_sum)]) begin
                pick  = ID_WIDTH'(scan_sum);
                found = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BURST;
                    owner_n = pick;
                    first_n = 1'b1;
`ifdef MAC_ARB_BURST_LIMIT_EN
                    cnt_n   = '0;
`endif
                end
            end
            BURST: begin
                fire     = bus.req_valid[owner];
                tag_last = bus.req_last[owner];
`ifdef MAC_ARB_BURST_LIMIT_EN
                // Beat MAX_BURST closes the vector; the owner's remaining beats wait for a new grant.
                if (fire) begin
                    cnt_n = beat_cnt + CNT_WIDTH'(1);
                end
                if (beat_cnt == CNT_WIDTH'(MAX_BURST - 1) && !tag_last) begin
                    tag_last  = 1'b1;
                    tag_trunc = 1'b1;
                end
`endif
                if (fire) begin
                    first_n = 1'b0;
                    mac_a_n = bus.req_a[owner*INPUT_WIDTH +: INPUT_WIDTH];
                    mac_b_n = bus.req_b[owner*INPUT_WIDTH +: INPUT_WIDTH];
                    if (tag_last) begin
                        state_n = IDLE;
                        rr_n    = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + ID_WIDTH'(1);
                    end
                end
            end
        endcase

        mac_clr_n       = fire & first_q;
        issue_n.valid   = fire;
        issue_n.last    = fire & tag_last;
        issue_n.id      = owner;
        issue_n.trunc   = fire & tag_trunc;

        pipe_n[0] = issue_q;
        for (int k = 1; k < int'(MAC_LATENCY); k++) begin
            pipe_n[k] = pipe_q[k-1];
        end

        ready_n = (state_n == BURST) ? (NUM_REQ'(1) << owner_n) : '0;

        busy_n = (state_n == BURST) | issue_n.valid;
        for (int k = 0; k < int'(MAC_LATENCY); k++) begin
            busy_n = busy_n | pipe_n[k].valid;
        end

        // Only the MAC result aligned with a vector's last beat is forwarded.
        res_valid_n = bus.mac_out_valid & pipe_q[LAST_TAG].valid & pipe_q[LAST_TAG].last;
        res_id_n    = res_valid_n ? pipe_q[LAST_TAG].id    : res_id_q;
        res_val_n   = res_valid_n ? bus.mac_out_val        : res_val_q;
        res_trunc_n = res_valid_n ? pipe_q[LAST_TAG].trunc : res_trunc_q;
    end

    // State and output registers; reset drops any in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            first_q     <= 1'b0;
            ready_q     <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_clr_q   <= 1'b0;
            issue_q     <= '0;
            for (int k = 0; k < int'(MAC_LATENCY); k++) begin
                pipe_q[k] <= '0;
            end
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_val_q   <= '0;
            res_trunc_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MAC_ARB_BURST_LIMIT_EN
            beat_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            rr_ptr      <= rr_n;
            first_q     <= first_n;
            ready_q     <= ready_n;
            mac_a_q     <= mac_a_n;
            mac_b_q     <= mac_b_n;
            mac_clr_q   <= mac_clr_n;
            issue_q     <= issue_n;
            for (int k = 0; k < int'(MAC_LATENCY); k++) begin
                pipe_q[k] <= pipe_n[k];
            end
            res_valid_q <= res_valid_n;
            res_id_q    <= res_id_n;
            res_val_q   <= res_val_n;
            res_trunc_q <= res_trunc_n;
            busy_q      <= busy_n;
`ifdef MAC_ARB_BURST_LIMIT_EN
            beat_cnt    <= cnt_n;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_valid = issue_q.valid;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_val   = res_val_q;
    assign bus.res_trunc = res_trunc_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Bench for mac_share_arbiter: requester drivers, a behavioural MAC, and a
// vector-level model of grant order, issued beats and returned results.
module tb_mac_share_arbiter;
    localparam int unsigned NR  = 4;
    localparam int unsigned IW  = 16;
    localparam int unsigned OW  = 40;
    localparam int unsigned LAT = 3;
`ifdef MAC_ARB_BURST_LIMIT_EN
    localparam int unsigned MAXB = 4;
`else
    localparam int unsigned MAXB = 64;
`endif

    typedef struct {
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic          last;
        int            hold;
    } beat_t;

    typedef struct {
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic          clr;
    } exp_beat_t;

    typedef struct {
        logic [1:0]    id;
        logic [OW-1:0] val;
        logic          trunc;
    } exp_res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_share_arbiter_if #(.NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    mac_share_arbiter #(
        .NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .MAC_LATENCY(LAT), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int beats_seen = 0;
    int res_seen   = 0;
    int trunc_seen = 0;
    logic [1:0]    last_res_id;
    logic [OW-1:0] last_res_val;
    int clr_cyc[$];

    beat_t     dq [NR][$];
    beat_t     mq [NR][$];
    exp_beat_t exp_beat[$];
    exp_res_t  exp_res[$];

    logic [NR-1:0] started;
    int            hold_cnt [NR];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC: accumulate on each valid beat, restart on clr, deliver LAT cycles later.
    logic [LAT-1:0] mv_pipe = '0;
    logic [OW-1:0]  mval_pipe [LAT];
    logic [OW-1:0]  acc = '0;
    logic [OW-1:0]  mac_nxt;
    always @(posedge clk) begin
        mac_nxt = acc;
        if (bus.mac_valid) begin
            mac_nxt = (bus.mac_clr ? '0 : acc) + OW'(bus.mac_a) * OW'(bus.mac_b);
            acc <= mac_nxt;
        end
        mv_pipe <= {mv_pipe[LAT-2:0], bus.mac_valid};
        mval_pipe[0] <= mac_nxt;
        for (int k = 1; k < int'(LAT); k++) mval_pipe[k] <= mval_pipe[k-1];
    end
    assign bus.mac_out_valid = mv_pipe[LAT-1];
    assign bus.mac_out_val   = mval_pipe[LAT-1];

    // Requester drivers: present the head beat after its hold gap, pop on valid&ready.
    initial begin
        logic [NR-1:0] fire;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        started       = '0;
        for (int i = 0; i < int'(NR); i++) hold_cnt[i] = 0;
        forever begin
            @(negedge clk);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NR); i++) begin
                if (fire[i] && dq[i].size() > 0) begin
                    dq[i].delete(0);
                    started[i] = 1'b0;
                end
                bus.req_valid[i] = 1'b0;
                bus.req_last[i]  = 1'b0;
                if (dq[i].size() > 0) begin
                    if (!started[i]) begin
                        hold_cnt[i] = dq[i][0].hold;
                        started[i]  = 1'b1;
                    end
                    if (hold_cnt[i] > 0) begin
                        hold_cnt[i]--;
                    end else begin
                        bus.req_valid[i]       = 1'b1;
                        bus.req_last[i]        = dq[i][0].last;
                        bus.req_a[i*IW +: IW]  = dq[i][0].a;
                        bus.req_b[i*IW +: IW]  = dq[i][0].b;
                    end
                end
            end
        end
    end

    // Compare process: every issued beat and every result against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mac_valid) begin
                exp_beat_t eb;
                beats_seen++;
                if (bus.mac_clr) clr_cyc.push_back(cyc);
                if (exp_beat.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat got a=%0h b=%0h clr=%0b required none", bus.mac_a, bus.mac_b, bus.mac_clr);
                end else begin
                    eb = exp_beat.pop_front();
                    chk("mac_beat", {bus.mac_a, bus.mac_b, bus.mac_clr}, {eb.a, eb.b, eb.clr});
                end
            end
            if (bus.res_valid) begin
                exp_res_t er;
                res_seen++;
                last_res_id  = bus.res_id;
                last_res_val = bus.res_val;
                if (bus.res_trunc) trunc_seen++;
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result got id=%0d val=%0h required none", bus.res_id, bus.res_val);
                end else begin
                    er = exp_res.pop_front();
                    chk("result", {bus.res_id, bus.res_val, bus.res_trunc}, {er.id, er.val, er.trunc});
                end
            end
        end
    end

    // Queue one vector on requester id; beat j = (a0+j*as, b0+j*bs), gap of hold_len before beat hold_idx.
    task automatic add_vec(input int id, input int n, input int a0, input int b0,
                           input int as, input int bs, input int hold_idx, input int hold_len);
        for (int j = 0; j < n; j++) begin
            beat_t bt;
            bt.a    = IW'(a0 + j*as);
            bt.b    = IW'(b0 + j*bs);
            bt.last = (j == n-1);
            bt.hold = (j == hold_idx) ? hold_len : 0;
            dq[id].push_back(bt);
            mq[id].push_back(bt);
        end
    endtask

    // Model: requester id receives the next grant; emit its beats and the expected result.
    task automatic expect_grant(input int id);
        logic [OW-1:0] sum = '0;
        int            n   = 0;
        logic          tr  = 1'b0;
        while (mq[id].size() > 0) begin
            beat_t     bt = mq[id].pop_front();
            exp_beat_t eb;
            n++;
            eb.a = bt.a; eb.b = bt.b; eb.clr = (n == 1);
            exp_beat.push_back(eb);
            sum = sum + OW'(bt.a) * OW'(bt.b);
            if (bt.last) break;
`ifdef MAC_ARB_BURST_LIMIT_EN
            if (n == int'(MAXB)) begin
                tr = 1'b1;
                break;
            end
`endif
        end
        begin
            exp_res_t er;
            er.id = 2'(id); er.val = sum; er.trunc = tr;
            exp_res.push_back(er);
        end
    endtask

    function automatic bit drivers_empty();
        for (int i = 0; i < int'(NR); i++) if (dq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!bus.busy && drivers_empty() && exp_beat.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_done"}, 128'(done), 128'(1));
        repeat (4) @(negedge clk);
        chk({name, "_drain"}, 128'(exp_beat.size() + exp_res.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {bus.req_ready, bus.mac_a, bus.mac_b, bus.mac_valid, bus.mac_clr,
                   bus.res_valid, bus.res_id, bus.res_val, bus.res_trunc, bus.busy}, '0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #2; rst = 1'b0;

        // Two-beat vector on req0: 2*3 + 4*5 = 26.
        @(posedge clk); #2;
        add_vec(0, 2, 2, 3, 2, 2, -1, 0);
        expect_grant(0);
        wait_idle("t2");
        chk("t2_res_count", 128'(res_seen), 128'(1));
        chk("t2_res_val", 128'(last_res_val), 128'(26));
        chk("t2_res_id", 128'(last_res_id), 128'(0));

        // Reset after beat 2 of a 4-beat req0 vector; pointer must return to 0.
        @(posedge clk); #2;
        target = beats_seen + 2;
        add_vec(0, 4, 7, 9, 1, 1, -1, 0);
        expect_grant(0);
        for (int n = 0; n < 100 && beats_seen < target; n++) @(posedge clk);
        chk("t1_beats_before_reset", 128'(beats_seen), 128'(target));
        #2;
        rst = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
            dq[i].delete();
            mq[i].delete();
            hold_cnt[i] = 0;
        end
        started = '0;
        exp_beat.delete();
        exp_res.delete();
        bus.req_valid = '0;
        bus.req_last  = '0;
        @(negedge clk);
        check_all_zero("t1_reset_outputs");
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        target = res_seen;
        add_vec(3, 2, 11, 12, 1, 1, -1, 0);
        add_vec(0, 2, 21, 22, 1, 1, -1, 0);
        expect_grant(0);
        expect_grant(3);
        wait_idle("t1");
        chk("t1_res_count", 128'(res_seen - target), 128'(2));

        // All four requesters: order 0,1,2,3,0 with one idle cycle between vectors.
        @(posedge clk); #2;
        clr_cyc.delete();
        add_vec(0, 2, 100, 1, 1, 1, -1, 0);
        add_vec(0, 2, 500, 5, 1, 1, -1, 0);
        add_vec(1, 2, 200, 2, 1, 1, -1, 0);
        add_vec(2, 2, 300, 3, 1, 1, -1, 0);
        add_vec(3, 2, 400, 4, 1, 1, -1, 0);
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        wait_idle("t3");
        chk("t3_vectors", 128'(clr_cyc.size()), 128'(5));
        for (int i = 1; i < clr_cyc.size(); i++)
            chk("t3_vector_spacing", 128'(clr_cyc[i] - clr_cyc[i-1]), 128'(3));

        // Move pointer to 3, then req1 and req3 together: 3 wins, then wraps to 1.
        @(posedge clk); #2;
        add_vec(2, 1, 33, 3, 0, 0, -1, 0);
        expect_grant(2);
        wait_idle("t4a");
        @(posedge clk); #2;
        add_vec(1, 2, 41, 4, 1, 1, -1, 0);
        add_vec(3, 2, 43, 6, 1, 1, -1, 0);
        expect_grant(3);
        expect_grant(1);
        wait_idle("t4");

        // req3 drops valid for 2 cycles mid-vector while req1 waits; grant stays on req3.
        @(posedge clk); #2;
        clr_cyc.delete();
        add_vec(3, 4, 5, 6, 1, 1, 2, 2);
        add_vec(1, 2, 8, 9, 1, 1, -1, 0);
        expect_grant(3);
        expect_grant(1);
        wait_idle("t5");
        chk("t5_vectors", 128'(clr_cyc.size()), 128'(2));
        if (clr_cyc.size() == 2)
            chk("t5_bubble_span", 128'(clr_cyc[1] - clr_cyc[0]), 128'(7));

        // Six-beat vector: split 4+2 with the burst cap, whole otherwise.
        @(posedge clk); #2;
        clr_cyc.delete();
        target = trunc_seen;
        add_vec(0, 6, 1, 2, 1, 1, -1, 0);
        expect_grant(0);
`ifdef MAC_ARB_BURST_LIMIT_EN
        expect_grant(0);
        wait_idle("t6");
        chk("t6_vectors", 128'(clr_cyc.size()), 128'(2));
        chk("t6_trunc_count", 128'(trunc_seen - target), 128'(1));
`else
        wait_idle("t6");
        chk("t6_vectors", 128'(clr_cyc.size()), 128'(1));
        chk("t6_trunc_count", 128'(trunc_seen - target), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
